if_stage: RTL
=============

Name: if_stage

Overview:
- Instruction-fetch stage of the 5-stage ARM-subset pipeline.
- Owns the program counter and drives the instruction memory address combinationally.
- Captures the returned 32-bit instruction into the IF/ID pipeline register.
- Handles stall (freeze from hazard unit) and taken-branch redirect and flush (from EX stage).

Parameters:
- RESET_PC, 32'd0, PC value loaded on reset.
- BUBBLE_INSTR, 32'd0, instruction word inserted into IF/ID on flush or bubble.
- CNT_WIDTH, 32, width of performance counters (used only with IF_PERF_CNT_EN).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- Freeze  input  1  hold PC and IF/ID contents (hazard stall).
- BranchTaken  input  1  redirect fetch and flush IF/ID.
- BranchAddr  input  32  branch target byte address.
- Instruction  input  32  word returned by instruction memory for InstAddr (combinational).
- InstAddr  output  32  address to instruction memory; equals PC register.
- IF_ID_PC  output  32  registered PC+4 of the captured instruction.
- IF_ID_Instr  output  32  registered instruction.
- IF_ID_Valid  output  1  IF/ID holds a real instruction.
- FetchCount  output  CNT_WIDTH  instructions captured (IF_PERF_CNT_EN only).
- StallCount  output  CNT_WIDTH  frozen cycles (IF_PERF_CNT_EN only).

Behaviour:
- Reset (rst_n low, async, takes effect immediately):
  - PC=RESET_PC; FSM=BOOT.
  - IF_ID_PC=0, IF_ID_Instr=BUBBLE_INSTR, IF_ID_Valid=0.
  - Counters=0.
- InstAddr = PC, combinational. Instruction is sampled in the same cycle, so an instruction at address A appears on IF_ID_Instr one clock after PC=A (latency 1).
- FSM states:
  - BOOT: one cycle after reset release. PC is not advanced; IF/ID loads a bubble (Valid=0). Always goes to RUN. Freeze and BranchTaken are ignored in BOOT.
  - RUN: normal fetch. Goes to STALL when Freeze=1 and BranchTaken=0.
  - STALL: PC and IF/ID hold. Returns to RUN when Freeze=0 or BranchTaken=1.
- Per-edge priority in RUN/STALL:
  1. BranchTaken=1: PC <= {BranchAddr[31:2],2'b00}; IF/ID loads a bubble (Instr=BUBBLE_INSTR, Valid=0, PC=0). Next state is RUN. Branch overrides Freeze.
  2. Freeze=1: PC, IF_ID_PC, IF_ID_Instr and IF_ID_Valid all hold.
  3. Otherwise: PC <= PC+4; IF_ID_PC <= PC+4; IF_ID_Instr <= Instruction; IF_ID_Valid <= 1.
- Arithmetic:
  - PC+4 is a 32-bit modular add; 0xFFFFFFFC wraps to 0x00000000 with no flag.
  - BranchAddr low two bits are forced to zero (word alignment).
- Instruction=0 (memory default) is captured as a valid instruction. No decoding happens here.
- Reset asserted mid-stall or mid-branch: all state returns to reset values immediately, regardless of Freeze or BranchTaken.

Optional Feature:
- Macro: IF_PERF_CNT_EN.
- Defined:
  - FetchCount increments on each edge where IF/ID loads with Valid=1.
  - StallCount increments on each edge where state is STALL, or RUN with Freeze=1, and BranchTaken=0.
  - Both saturate at all-ones.
- Undefined:
  - FetchCount and StallCount ports are absent.
  - No counter logic is synthesized.
  - All other behaviour is identical.

Test Plan:
- Reset: hold rst_n=0, then release -> InstAddr=0, IF_ID_Valid=0, IF_ID_Instr=0. BOOT cycle keeps InstAddr=0; next edge captures word at address 0 with IF_ID_PC=4.
- Sequential fetch: memory returns 0xE3A00014 at 0, 0xE3A01A01 at 4 -> over two RUN cycles IF_ID_Instr=0xE3A00014 then 0xE3A01A01, IF_ID_PC=4 then 8, InstAddr=8.
- Freeze at PC=12 for 2 cycles -> InstAddr stays 12, IF/ID unchanged. On release, next edge captures the word at 12, IF_ID_PC=16. StallCount=2 with IF_PERF_CNT_EN.
- Branch at PC=0x90 with BranchAddr=0x70 -> next InstAddr=0x70, IF_ID_Valid=0, IF_ID_Instr=0. The following edge captures the word at 0x70 with IF_ID_PC=0x74.
- BranchTaken=1 and Freeze=1 together, BranchAddr=0x93 -> InstAddr=0x90, IF/ID bubble, state RUN.
- Async reset mid-stall: PC=0x40, Freeze=1, drop rst_n between edges -> InstAddr=0 and IF_ID_Valid=0 immediately. PC=0xFFFFFFFC in RUN -> next InstAddr=0x00000000.

Source files
------------

// File: rtl/if_stage.sv
// if_stage: instruction fetch, owns the PC and the IF/ID register.
// Optional perf counters (FetchCount/StallCount) under IF_PERF_CNT_EN.
package if_stage_pkg;
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        valid;
  } if_id_t;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    RUN   = 2'd1,
    STALL = 2'd2
  } if_state_t;
endpackage

module if_stage
  import if_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC     = 32'd0,
  parameter logic [31:0] BUBBLE_INSTR = 32'd0,
  parameter int          CNT_WIDTH    = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 Freeze,
  input  logic                 BranchTaken,
  input  logic [31:0]          BranchAddr,
  input  logic [31:0]          Instruction,
  output logic [31:0]          InstAddr,
  output logic [31:0]          IF_ID_PC,
  output logic [31:0]          IF_ID_Instr,
`ifdef IF_PERF_CNT_EN
  output logic [CNT_WIDTH-1:0] FetchCount,
  output logic [CNT_WIDTH-1:0] StallCount,
`endif
  output logic                 IF_ID_Valid
);

  localparam if_id_t BUBBLE = '{
    pc:    32'd0,
    instr: BUBBLE_INSTR,
    valid: 1'b0
  };

  if_state_t   state, state_n;
  logic [31:0] pc, pc_n, pc_inc;
  if_id_t      ifid, ifid_n;

  assign pc_inc      = pc + 32'd4;
  assign InstAddr    = pc;
  assign IF_ID_PC    = ifid.pc;
  assign IF_ID_Instr = ifid.instr;
  assign IF_ID_Valid = ifid.valid;

  always_comb begin
    state_n = state;
    pc_n    = pc;
    ifid_n  = ifid;
    unique case (state)
      BOOT: begin
        state_n = RUN;
        ifid_n  = BUBBLE;
      end
      RUN, STALL: begin
        unique case (1'b1)
          BranchTaken: begin
            state_n = RUN;
            pc_n    = {BranchAddr[31:2], 2'b00};
            ifid_n  = BUBBLE;
          end
          (!BranchTaken && Freeze): begin
            state_n = STALL;
          end
          (!BranchTaken && !Freeze): begin
            state_n = RUN;
            pc_n    = pc_inc;
            ifid_n  = '{pc: pc_inc, instr: Instruction, valid: 1'b1};
          end
          default: ;
        endcase
      end
      default: begin
        state_n = BOOT;
        ifid_n  = BUBBLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= BOOT;
      pc    <= RESET_PC;
      ifid  <= BUBBLE;
    end else begin
      state <= state_n;
      pc    <= pc_n;
      ifid  <= ifid_n;
    end
  end

`ifdef IF_PERF_CNT_EN
  logic active, fetch_inc, stall_inc;

  // BOOT neither fetches nor counts as a stall
  assign active    = (state != BOOT) && !BranchTaken;
  assign fetch_inc = active && !Freeze;
  assign stall_inc = active && Freeze;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      FetchCount <= '0;
      StallCount <= '0;
    end else begin
      if (fetch_inc && (FetchCount != '1))
        FetchCount <= FetchCount + 1'b1;
      if (stall_inc && (StallCount != '1))
        StallCount <= StallCount + 1'b1;
    end
  end
`endif

endmodule
